smem_request_serializer: RTL and testbench

- Requester-side front end for the banked shared-memory scratchpad.
- Accepts one 8-lane warp access (read or write), splits it into bank-conflict-free passes and drives the per-bank port.
- Collects read data (1-cycle bank latency) into per-lane results and returns a single response.
- Sits between the compute unit's load/store path and the shared-memory banks.

---
 rtl/smem_pkg.sv | 31 +++
 rtl/smem_bank_grant.sv | 32 +++
 rtl/smem_request_serializer.sv | 213 +++++++++++++++++++++
 tb/tb_smem_request_serializer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_pkg.sv
// Shared types, widths and address helpers for the shared-memory request serializer.
package smem_pkg;

   localparam int unsigned NUM_LANES     = 8;
   localparam int unsigned NUM_BANKS     = 8;
   localparam int unsigned ADDRESS_WIDTH = 8;
   localparam int unsigned DATA_WIDTH    = 16;
   localparam int unsigned BANK_IDX_W    = $clog2(NUM_BANKS);
   localparam int unsigned LANE_IDX_W    = $clog2(NUM_LANES);
   localparam int unsigned ROW_WIDTH     = ADDRESS_WIDTH - BANK_IDX_W;
   localparam int unsigned PASS_W        = 4;
   localparam int unsigned PASS_MAX      = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Bank index is the low address bits.
   function automatic logic [BANK_IDX_W-1:0] bank_of(input logic [ADDRESS_WIDTH-1:0] addr);
      return addr[BANK_IDX_W-1:0];
   endfunction

   // Row within a bank is the remaining high address bits.
   function automatic logic [ROW_WIDTH-1:0] row_of(input logic [ADDRESS_WIDTH-1:0] addr);
      return addr[ADDRESS_WIDTH-1:BANK_IDX_W];
   endfunction

endpackage

// File: rtl/smem_bank_grant.sv
// Per-bank arbiter: each bank grants the lowest-index pending lane that maps to it.
module smem_bank_grant
   import smem_pkg::*;
(
   input  logic [NUM_LANES-1:0]            pending,
   input  logic [NUM_LANES*BANK_IDX_W-1:0] lane_bank,
   output logic [NUM_BANKS-1:0]            grant_valid,
   output logic [NUM_BANKS*LANE_IDX_W-1:0] grant_lane,
   output logic [NUM_LANES-1:0]            lane_grant
);

   // Lowest-lane-first selection per bank, then fan the winners back out per lane.
   always_comb begin
      logic found;
      grant_valid = '0;
      grant_lane  = '0;
      lane_grant  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         found = 1'b0;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (!found && pending[l] &&
                (lane_bank[l*BANK_IDX_W +: BANK_IDX_W] == BANK_IDX_W'(b))) begin
               found                                 = 1'b1;
               grant_valid[b]                        = 1'b1;
               grant_lane[b*LANE_IDX_W +: LANE_IDX_W] = LANE_IDX_W'(l);
               lane_grant[l]                         = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/smem_request_serializer.sv
// Splits one warp access into bank-conflict-free passes, drives the bank port
// and gathers read data into a single per-lane response.
module smem_request_serializer
   import smem_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_write,
   input  logic [NUM_LANES-1:0]              req_mask,
   input  logic [NUM_LANES*ADDRESS_WIDTH-1:0] req_addr,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_BANKS-1:0]              bank_en,
   output logic                              bank_we,
   output logic [NUM_BANKS*ROW_WIDTH-1:0]    bank_row,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]   bank_wdata,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0]   bank_rdata,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [NUM_LANES*DATA_WIDTH-1:0]   rsp_data,
   output logic [PASS_W-1:0]                 rsp_passes
);

   state_t                             state_q, state_d;
   logic                               write_q, write_d;
   logic [NUM_LANES*ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [NUM_LANES*DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [NUM_LANES-1:0]               pending_q, pending_d;
   logic [NUM_LANES*DATA_WIDTH-1:0]    result_q, result_d;
   logic [PASS_W-1:0]                  passes_q, passes_d;
   logic [NUM_BANKS-1:0]               bank_en_q, bank_en_d;
   logic                               bank_we_q, bank_we_d;
   logic [NUM_BANKS*ROW_WIDTH-1:0]     bank_row_q, bank_row_d;
   logic [NUM_BANKS*DATA_WIDTH-1:0]    bank_wdata_q, bank_wdata_d;
   logic [NUM_BANKS*LANE_IDX_W-1:0]    bank_lane_q, bank_lane_d;
   logic [NUM_BANKS-1:0]               cap_valid_q, cap_valid_d;
   logic [NUM_BANKS*LANE_IDX_W-1:0]    cap_lane_q, cap_lane_d;
   logic                               req_ready_q, req_ready_d;
   logic                               rsp_valid_q, rsp_valid_d;
   logic                               issue;

   // The first pass is arbitrated straight from the request so it can be on the port the cycle after accept.
   logic                               in_idle;
   logic [NUM_LANES-1:0]               sel_pending;
   logic [NUM_LANES*ADDRESS_WIDTH-1:0] sel_addr;
   logic [NUM_LANES*DATA_WIDTH-1:0]    sel_wdata;
   logic                               sel_write;
   logic [NUM_LANES*BANK_IDX_W-1:0]    lane_bank;
   logic [NUM_BANKS-1:0]               grant_valid;
   logic [NUM_BANKS*LANE_IDX_W-1:0]    grant_lane;
   logic [NUM_LANES-1:0]               lane_grant;

   assign in_idle     = (state_q == IDLE);
   assign sel_pending = in_idle ? req_mask  : pending_q;
   assign sel_addr    = in_idle ? req_addr  : addr_q;
   assign sel_wdata   = in_idle ? req_wdata : wdata_q;
   assign sel_write   = in_idle ? req_write : write_q;

   // Bank index of every lane feeding the arbiter.
   always_comb begin
      lane_bank = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         lane_bank[l*BANK_IDX_W +: BANK_IDX_W] = bank_of(sel_addr[l*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
      end
   end

   smem_bank_grant u_grant (
      .pending     (sel_pending),
      .lane_bank   (lane_bank),
      .grant_valid (grant_valid),
      .grant_lane  (grant_lane),
      .lane_grant  (lane_grant)
   );

   // Next-state and next-register values.
   always_comb begin
      int unsigned lane;
      state_d      = state_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      pending_d    = pending_q;
      result_d     = result_q;
      passes_d     = passes_q;
      bank_en_d    = '0;
      bank_we_d    = 1'b0;
      bank_row_d   = '0;
      bank_wdata_d = '0;
      bank_lane_d  = '0;
      cap_valid_d  = bank_we_q ? '0 : bank_en_q;
      cap_lane_d   = bank_lane_q;
      issue        = 1'b0;
      lane         = 0;

      // Read data from the previous issue cycle lands in the granted lanes.
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (cap_valid_q[b]) begin
            lane = 32'(cap_lane_q[b*LANE_IDX_W +: LANE_IDX_W]);
            result_d[lane*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               write_d  = req_write;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               result_d = '0;
               if (req_mask == '0) begin
                  pending_d = '0;
                  passes_d  = '0;
                  state_d   = RESP;
               end else begin
                  issue    = 1'b1;
                  passes_d = PASS_W'(1);
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (pending_q == '0) begin
               state_d = DRAIN;
            end else begin
               issue    = 1'b1;
               passes_d = (passes_q == PASS_W'(PASS_MAX)) ? passes_q : passes_q + PASS_W'(1);
            end
         end
         DRAIN: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               result_d = '0;
               passes_d = '0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Load the next pass onto the bank port and retire its lanes.
      if (issue) begin
         bank_en_d   = grant_valid;
         bank_we_d   = sel_write;
         bank_lane_d = grant_lane;
         pending_d   = sel_pending & ~lane_grant;
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_valid[b]) begin
               lane = 32'(grant_lane[b*LANE_IDX_W +: LANE_IDX_W]);
               bank_row_d[b*ROW_WIDTH +: ROW_WIDTH] =
                  row_of(sel_addr[lane*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
               bank_wdata_d[b*DATA_WIDTH +: DATA_WIDTH] = sel_wdata[lane*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         pending_q    <= '0;
         result_q     <= '0;
         passes_q     <= '0;
         bank_en_q    <= '0;
         bank_we_q    <= 1'b0;
         bank_row_q   <= '0;
         bank_wdata_q <= '0;
         bank_lane_q  <= '0;
         cap_valid_q  <= '0;
         cap_lane_q   <= '0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         pending_q    <= pending_d;
         result_q     <= result_d;
         passes_q     <= passes_d;
         bank_en_q    <= bank_en_d;
         bank_we_q    <= bank_we_d;
         bank_row_q   <= bank_row_d;
         bank_wdata_q <= bank_wdata_d;
         bank_lane_q  <= bank_lane_d;
         cap_valid_q  <= cap_valid_d;
         cap_lane_q   <= cap_lane_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign bank_en    = bank_en_q;
   assign bank_we    = bank_we_q;
   assign bank_row   = bank_row_q;
   assign bank_wdata = bank_wdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = result_q;
   assign rsp_passes = passes_q;

endmodule

// File: tb/tb_smem_request_serializer.sv
// Scoreboard bench for the shared-memory request serializer with a 1-cycle bank model.
module tb_smem_request_serializer;

   localparam int NL = 8;
   localparam int NB = 8;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int RW = 5;

   typedef struct {
      logic [NL*DW-1:0] data;
      logic [3:0]       passes;
      int               lat;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_write;
   logic [NL-1:0]     req_mask;
   logic [NL*AW-1:0]  req_addr;
   logic [NL*DW-1:0]  req_wdata;
   logic [NB-1:0]     bank_en;
   logic              bank_we;
   logic [NB*RW-1:0]  bank_row;
   logic [NB*DW-1:0]  bank_wdata;
   logic [NB*DW-1:0]  bank_rdata = '0;
   logic              rsp_valid, rsp_ready;
   logic [NL*DW-1:0]  rsp_data;
   logic [3:0]        rsp_passes;

   int vectors    = 0;
   int miscompares = 0;

   logic [DW-1:0] mem     [NB][32];
   logic [DW-1:0] ref_mem [NB][32];
   bit            loaded = 1'b0;
   exp_t          sb[$];

   // Observations from the last transaction.
   int               obs_lat;
   logic [NL*DW-1:0] obs_data;
   logic [3:0]       obs_passes;
   bit               obs_rdy_low_ok, obs_stable, obs_any_en;
   logic             obs_post_ready, obs_post_valid;
   logic [NB-1:0]    trace_en  [16];
   logic [NB*RW-1:0] trace_row [16];

   smem_request_serializer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_mask   (req_mask),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .bank_en    (bank_en),
      .bank_we    (bank_we),
      .bank_row   (bank_row),
      .bank_wdata (bank_wdata),
      .bank_rdata (bank_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_passes (rsp_passes)
   );

   always #5 clk = ~clk;

   // Bank array: preload row*16+bank, then read data one cycle after bank_en.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int b = 0; b < NB; b++)
            for (int r = 0; r < 32; r++) mem[b][r] <= DW'(r*16 + b);
         loaded <= 1'b1;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (bank_en[b]) begin
               if (bank_we) mem[b][bank_row[b*RW +: RW]] <= bank_wdata[b*DW +: DW];
               bank_rdata[b*DW +: DW] <= bank_we ? '0 : mem[b][bank_row[b*RW +: RW]];
            end else begin
               bank_rdata[b*DW +: DW] <= '0;
            end
         end
      end
   end

   // Reference model: expected response and memory update for one request.
   function automatic exp_t model(input logic wr, input logic [NL-1:0] mask,
                                  input logic [NL*AW-1:0] addr, input logic [NL*DW-1:0] wdata);
      exp_t e;
      int   cnt[NB];
      int   mx;
      logic [AW-1:0] a;
      e.data = '0;
      mx = 0;
      for (int b = 0; b < NB; b++) cnt[b] = 0;
      for (int l = 0; l < NL; l++) begin
         if (mask[l]) begin
            a = addr[l*AW +: AW];
            cnt[a[2:0]]++;
            if (!wr) e.data[l*DW +: DW] = ref_mem[a[2:0]][a[7:3]];
         end
      end
      for (int l = 0; l < NL; l++) begin
         if (wr && mask[l]) begin
            a = addr[l*AW +: AW];
            ref_mem[a[2:0]][a[7:3]] = wdata[l*DW +: DW];
         end
      end
      for (int b = 0; b < NB; b++) if (cnt[b] > mx) mx = cnt[b];
      e.passes = 4'(mx);
      e.lat    = (mask == '0) ? 1 : mx + 2;
      return e;
   endfunction

   // Drive one request and record what the DUT does until after the response handshake.
   task automatic run_txn(input logic wr, input logic [NL-1:0] mask, input logic [NL*AW-1:0] addr,
                          input logic [NL*DW-1:0] wdata, input int hold);
      int cyc;
      @(negedge clk);
      rsp_ready = (hold == 0);
      req_valid = 1'b1; req_write = wr; req_mask = mask; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1; obs_rdy_low_ok = 1'b1; obs_any_en = 1'b0;
      for (int i = 0; i < 16; i++) begin trace_en[i] = '0; trace_row[i] = '0; end
      while (rsp_valid !== 1'b1 && cyc < 40) begin
         if (req_ready !== 1'b0) obs_rdy_low_ok = 1'b0;
         if (bank_en !== '0) obs_any_en = 1'b1;
         if (cyc < 16) begin trace_en[cyc] = bank_en; trace_row[cyc] = bank_row; end
         @(negedge clk);
         cyc++;
      end
      obs_lat = cyc; obs_data = rsp_data; obs_passes = rsp_passes; obs_stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== obs_data ||
             rsp_passes !== obs_passes || bank_en !== '0) obs_stable = 1'b0;
         @(negedge clk);
      end
      if (bank_en !== '0) obs_any_en = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      obs_post_ready = req_ready; obs_post_valid = rsp_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_mask = '0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      for (int b = 0; b < NB; b++) for (int r = 0; r < 32; r++) ref_mem[b][r] = DW'(r*16 + b);
      repeat (3) @(negedge clk);
      vectors++; if (bank_en !== '0 || bank_we !== 1'b0 || bank_row !== '0 || bank_wdata !== '0) begin
         miscompares++; $display("FAIL reset_bank: en=%h we=%b row=%h want all 0", bank_en, bank_we, bank_row); end
      vectors++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_passes !== 4'd0) begin
         miscompares++; $display("FAIL reset_rsp: valid=%b passes=%0d want 0", rsp_valid, rsp_passes); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_distinct_banks();
      logic [NL*AW-1:0] addr;
      exp_t e;
      for (int i = 0; i < NL; i++) addr[i*AW +: AW] = AW'(8*i + i);
      sb.push_back(model(1'b0, 8'hFF, addr, '0));
      run_txn(1'b0, 8'hFF, addr, '0, 0);
      e = sb.pop_front();
      vectors++; if (obs_lat !== e.lat) begin miscompares++; $display("FAIL t1_latency: got %0d want %0d", obs_lat, e.lat); end
      vectors++; if (obs_passes !== e.passes) begin miscompares++; $display("FAIL t1_passes: got %0d want %0d", obs_passes, e.passes); end
      vectors++; if (obs_data !== e.data) begin miscompares++; $display("FAIL t1_data: got %h want %h", obs_data, e.data); end
      vectors++; if (obs_data[3*DW +: DW] !== 16'h0033) begin miscompares++; $display("FAIL t1_lane3: got %h want 0033", obs_data[3*DW +: DW]); end
      vectors++; if (trace_en[1] !== 8'hFF || trace_en[2] !== 8'h00) begin
         miscompares++; $display("FAIL t1_bank_en: c1=%h c2=%h want ff 00", trace_en[1], trace_en[2]); end
      vectors++; if (!obs_rdy_low_ok || obs_post_ready !== 1'b1 || obs_post_valid !== 1'b0) begin
         miscompares++; $display("FAIL t1_ready: low_ok=%b post_ready=%b post_valid=%b want 1 1 0", obs_rdy_low_ok, obs_post_ready, obs_post_valid); end
   endtask

   task automatic test_full_conflict();
      logic [NL*AW-1:0] addr;
      exp_t e;
      bit   order_ok;
      for (int i = 0; i < NL; i++) addr[i*AW +: AW] = AW'(8*i + 2);
      sb.push_back(model(1'b0, 8'hFF, addr, '0));
      run_txn(1'b0, 8'hFF, addr, '0, 0);
      e = sb.pop_front();
      order_ok = 1'b1;
      for (int c = 1; c <= 8; c++)
         if (trace_en[c] !== 8'h04 || trace_row[c][14:10] !== 5'(c-1)) order_ok = 1'b0;
      if (trace_en[9] !== 8'h00) order_ok = 1'b0;
      vectors++; if (!order_ok) begin miscompares++; $display("FAIL t2_order: c1=%h c8=%h c9=%h row8=%0d want 04 04 00 7", trace_en[1], trace_en[8], trace_en[9], trace_row[8][14:10]); end
      vectors++; if (obs_passes !== e.passes || obs_passes !== 4'd8) begin miscompares++; $display("FAIL t2_passes: got %0d want 8", obs_passes); end
      vectors++; if (obs_lat !== 10) begin miscompares++; $display("FAIL t2_latency: got %0d want 10", obs_lat); end
      vectors++; if (obs_data !== e.data) begin miscompares++; $display("FAIL t2_data: got %h want %h", obs_data, e.data); end
   endtask

   task automatic test_dup_write();
      logic [NL*AW-1:0] addr;
      logic [NL*DW-1:0] wd;
      exp_t e;
      addr = {8'h27, 8'h26, 8'h13, 8'h25, 8'h24, 8'h22, 8'h21, 8'h13};
      for (int i = 0; i < NL; i++) wd[i*DW +: DW] = DW'(16'h1000 + i);
      wd[0*DW +: DW] = 16'hAAAA;
      wd[5*DW +: DW] = 16'h5555;
      sb.push_back(model(1'b1, 8'hFF, addr, wd));
      run_txn(1'b1, 8'hFF, addr, wd, 0);
      e = sb.pop_front();
      vectors++; if (obs_passes !== e.passes || obs_passes !== 4'd2) begin miscompares++; $display("FAIL t3_passes: got %0d want 2", obs_passes); end
      vectors++; if (obs_data !== '0) begin miscompares++; $display("FAIL t3_wdata_rsp: got %h want 0", obs_data); end
      addr = '0; addr[7:0] = 8'h13;
      sb.push_back(model(1'b0, 8'h01, addr, '0));
      run_txn(1'b0, 8'h01, addr, '0, 0);
      e = sb.pop_front();
      vectors++; if (obs_data !== e.data || obs_data[15:0] !== 16'h5555) begin miscompares++; $display("FAIL t3_readback: got %h want 5555", obs_data[15:0]); end
      addr[7:0] = 8'h24;
      sb.push_back(model(1'b0, 8'h01, addr, '0));
      run_txn(1'b0, 8'h01, addr, '0, 0);
      e = sb.pop_front();
      vectors++; if (obs_data !== e.data) begin miscompares++; $display("FAIL t3_readback2: got %h want %h", obs_data[15:0], e.data[15:0]); end
   endtask

   task automatic test_empty_mask();
      exp_t e;
      sb.push_back(model(1'b0, 8'h00, 64'h0706050403020100, '0));
      run_txn(1'b0, 8'h00, 64'h0706050403020100, '0, 0);
      e = sb.pop_front();
      vectors++; if (obs_lat !== e.lat || obs_lat !== 1) begin miscompares++; $display("FAIL t4_latency: got %0d want 1", obs_lat); end
      vectors++; if (obs_passes !== 4'd0 || obs_data !== '0) begin miscompares++; $display("FAIL t4_rsp: passes=%0d data=%h want 0", obs_passes, obs_data); end
      vectors++; if (obs_any_en) begin miscompares++; $display("FAIL t4_bank_en: got activity want none"); end
   endtask

   task automatic test_backpressure();
      logic [NL*AW-1:0] addr;
      exp_t e;
      addr = '0;
      addr[0*AW +: AW] = 8'h08;
      addr[7*AW +: AW] = 8'h3F;
      for (int i = 1; i < 7; i++) addr[i*AW +: AW] = AW'(i);
      sb.push_back(model(1'b0, 8'h81, addr, '0));
      run_txn(1'b0, 8'h81, addr, '0, 5);
      e = sb.pop_front();
      vectors++; if (obs_data !== e.data) begin miscompares++; $display("FAIL t5_data: got %h want %h", obs_data, e.data); end
      vectors++; if (obs_data[7*DW-1:DW] !== '0) begin miscompares++; $display("FAIL t5_masked_lanes: got %h want 0", obs_data[7*DW-1:DW]); end
      vectors++; if (!obs_stable || !obs_rdy_low_ok) begin miscompares++; $display("FAIL t5_hold: stable=%b ready_low=%b want 1 1", obs_stable, obs_rdy_low_ok); end
      vectors++; if (obs_post_ready !== 1'b1 || obs_post_valid !== 1'b0) begin miscompares++; $display("FAIL t5_release: ready=%b valid=%b want 1 0", obs_post_ready, obs_post_valid); end
      vectors++; if (obs_passes !== e.passes) begin miscompares++; $display("FAIL t5_passes: got %0d want %0d", obs_passes, e.passes); end
   endtask

   task automatic test_reset_abort();
      logic [NL*AW-1:0] addr;
      exp_t e;
      bit   seen;
      for (int i = 0; i < NL; i++) addr[i*AW +: AW] = AW'(8*i + 2);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_mask = 8'hFF; req_addr = addr; rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (bank_en !== 8'h04) begin miscompares++; $display("FAIL t6_midflight: got %h want 04", bank_en); end
      rst_n = 1'b0;
      #1;
      vectors++; if (bank_en !== '0 || bank_row !== '0 || rsp_valid !== 1'b0 || rsp_passes !== 4'd0 || req_ready !== 1'b0) begin
         miscompares++; $display("FAIL t6_reset_out: en=%h valid=%b passes=%0d ready=%b want 0", bank_en, rsp_valid, rsp_passes, req_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
      vectors++; if (seen || req_ready !== 1'b1) begin miscompares++; $display("FAIL t6_no_rsp: seen=%b ready=%b want 0 1", seen, req_ready); end
      for (int i = 0; i < NL; i++) addr[i*AW +: AW] = AW'(8*i + i);
      sb.push_back(model(1'b0, 8'hFF, addr, '0));
      run_txn(1'b0, 8'hFF, addr, '0, 0);
      e = sb.pop_front();
      vectors++; if (obs_data !== e.data || obs_passes !== e.passes || obs_lat !== e.lat) begin
         miscompares++; $display("FAIL t6_after: lat=%0d passes=%0d want %0d %0d", obs_lat, obs_passes, e.lat, e.passes); end
   endtask

   initial begin
      test_reset();
      test_distinct_banks();
      test_full_conflict();
      test_dup_write();
      test_empty_mask();
      test_backpressure();
      test_reset_abort();
      vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
